// File: rtl/action_write_arbiter_if.sv
// Bundle between the per-thread action sources, the regfile action-write port and the arbiter.
// Handshake: a request word is taken on a rising edge where req_valid_in[t] && req_ready_out[t].
interface action_write_arbiter_if #(
  parameter int NUM_ACTIONS = 4,
  parameter int THREAD_BITS = 2,
  parameter int STALL_BITS  = 8
);
  localparam int NUM_THREADS = 2 ** THREAD_BITS;

  logic [NUM_THREADS-1:0]             req_valid_in;
  logic [NUM_THREADS*NUM_ACTIONS-1:0] req_data_in;
  logic [NUM_THREADS-1:0]             req_ready_out;
  logic                               pipe_wena_in;
  logic                               action_wen_out;
  logic [THREAD_BITS-1:0]             action_thread_id_out;
  logic [NUM_ACTIONS-1:0]             action_data_out;
  logic [NUM_THREADS-1:0]             done_out;
  logic [STALL_BITS-1:0]              stall_count_out;

  // slave: the arbiter itself
  modport slave (
    input  req_valid_in, req_data_in, pipe_wena_in,
    output req_ready_out, action_wen_out, action_thread_id_out,
           action_data_out, done_out, stall_count_out
  );

  // master: action sources plus the regfile's pipeline-write indication
  modport master (
    output req_valid_in, req_data_in, pipe_wena_in,
    input  req_ready_out, action_wen_out, action_thread_id_out,
           action_data_out, done_out, stall_count_out
  );
endinterface

// File: rtl/action_write_arbiter.sv
// One-entry action slot per thread, round-robin serialised onto the regfile action-write port.
// An issued action retries every cycle until the regfile pipeline write (pipe_wena_in) is low.
module action_write_arbiter #(
  parameter int NUM_ACTIONS = 4,
  parameter int THREAD_BITS = 2,
  parameter int STALL_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  action_write_arbiter_if.slave bus
);
  localparam int NUM_THREADS = 2 ** THREAD_BITS;

  logic [NUM_THREADS-1:0] r_slot_valid;
  logic [NUM_ACTIONS-1:0] r_slot_data [NUM_THREADS];
  logic                   r_issue_valid;
  logic [THREAD_BITS-1:0] r_issue_tid;
  logic [NUM_ACTIONS-1:0] r_issue_data;
  logic [THREAD_BITS-1:0] r_rr;
  logic [NUM_THREADS-1:0] r_done;
  logic [STALL_BITS-1:0]  r_stall_count;

  logic [NUM_THREADS-1:0] w_eligible;
  logic                   w_grant_found;
  logic [THREAD_BITS-1:0] w_grant_tid;
  logic                   w_commit;
  logic                   w_stall;
  logic                   w_load;

  // The thread sitting in the issue stage must not be picked again while it is there.
  always_comb begin
    w_eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_eligible[t] = r_slot_valid[t] && !(r_issue_valid && (r_issue_tid == THREAD_BITS'(t)));
    end
  end

  always_comb begin
    logic [THREAD_BITS-1:0] w_idx;
    w_idx         = '0;
    w_grant_found = 1'b0;
    w_grant_tid   = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      w_idx = r_rr + THREAD_BITS'(k);
      if (!w_grant_found && w_eligible[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_tid   = w_idx;
      end
    end
  end

  assign w_commit = r_issue_valid && !bus.pipe_wena_in;
  assign w_stall  = r_issue_valid && bus.pipe_wena_in;
  assign w_load   = (!r_issue_valid || w_commit) && w_grant_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid  <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_slot_data[t] <= '0;
      end
      r_issue_valid <= 1'b0;
      r_issue_tid   <= '0;
      r_issue_data  <= '0;
      r_rr          <= '0;
      r_done        <= '0;
      r_stall_count <= '0;
    end else begin
      // A slot is never accepted into while valid, so accept and commit never hit the same thread.
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (bus.req_valid_in[t] && !r_slot_valid[t]) begin
          r_slot_valid[t] <= 1'b1;
          r_slot_data[t]  <= bus.req_data_in[t*NUM_ACTIONS +: NUM_ACTIONS];
        end
      end

      r_done <= '0;
      if (w_commit) begin
        r_slot_valid[r_issue_tid] <= 1'b0;
        r_done[r_issue_tid]       <= 1'b1;
      end

      if (w_load) begin
        r_issue_valid <= 1'b1;
        r_issue_tid   <= w_grant_tid;
        r_issue_data  <= r_slot_data[w_grant_tid];
        r_rr          <= w_grant_tid + 1'b1;
      end else if (w_commit) begin
        r_issue_valid <= 1'b0;
      end

      if (w_stall && (r_stall_count != {STALL_BITS{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign bus.req_ready_out        = ~r_slot_valid;
  assign bus.action_wen_out       = r_issue_valid;
  assign bus.action_thread_id_out = r_issue_valid ? r_issue_tid  : '0;
  assign bus.action_data_out      = r_issue_valid ? r_issue_data : '0;
  assign bus.done_out             = r_done;
  assign bus.stall_count_out      = r_stall_count;
endmodule

// File: tb/tb_action_write_arbiter.sv
// Directed bench for action_write_arbiter: latency, ordering, stalls, held requests, mid-flight reset.
module tb_action_write_arbiter;
  localparam int NA = 4;
  localparam int TB = 2;
  localparam int SB = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  action_write_arbiter_if #(.NUM_ACTIONS(NA), .THREAD_BITS(TB), .STALL_BITS(SB)) bus ();

  action_write_arbiter #(.NUM_ACTIONS(NA), .THREAD_BITS(TB), .STALL_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid_in = '0;
    bus.req_data_in  = '0;
    bus.pipe_wena_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL rst_wen: got %0h expected 0", bus.action_wen_out); end
    checks++; if (bus.action_thread_id_out !== 2'd0) begin errors++; $display("FAIL rst_tid: got %0h expected 0", bus.action_thread_id_out); end
    checks++; if (bus.action_data_out !== 4'h0) begin errors++; $display("FAIL rst_data: got %0h expected 0", bus.action_data_out); end
    checks++; if (bus.done_out !== 4'h0) begin errors++; $display("FAIL rst_done: got %0h expected 0", bus.done_out); end
    checks++; if (bus.stall_count_out !== 8'h00) begin errors++; $display("FAIL rst_stall: got %0h expected 0", bus.stall_count_out); end
    checks++; if (bus.req_ready_out !== 4'hF) begin errors++; $display("FAIL rst_ready: got %0h expected f", bus.req_ready_out); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid_in = 4'b0001;
    bus.req_data_in  = 16'h000A;
    step();
    bus.req_valid_in = '0;
    checks++; if (bus.req_ready_out !== 4'hE) begin errors++; $display("FAIL t1_ready_acc: got %0h expected e", bus.req_ready_out); end
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t1_wen_early: got %0h expected 0", bus.action_wen_out); end
    step();
    checks++; if (bus.action_wen_out !== 1'b1) begin errors++; $display("FAIL t1_wen: got %0h expected 1", bus.action_wen_out); end
    checks++; if (bus.action_thread_id_out !== 2'd0) begin errors++; $display("FAIL t1_tid: got %0h expected 0", bus.action_thread_id_out); end
    checks++; if (bus.action_data_out !== 4'hA) begin errors++; $display("FAIL t1_data: got %0h expected a", bus.action_data_out); end
    step();
    checks++; if (bus.done_out !== 4'b0001) begin errors++; $display("FAIL t1_done: got %0h expected 1", bus.done_out); end
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t1_wen_off: got %0h expected 0", bus.action_wen_out); end
    checks++; if (bus.req_ready_out !== 4'hF) begin errors++; $display("FAIL t1_ready_back: got %0h expected f", bus.req_ready_out); end
    step();
    checks++; if (bus.done_out !== 4'h0) begin errors++; $display("FAIL t1_done_pulse: got %0h expected 0", bus.done_out); end
  endtask

  task automatic test_all_threads();
    logic [3:0] exp_done [5];
    exp_done = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    bus.req_valid_in = 4'hF;
    bus.req_data_in  = 16'h4321;
    step();
    bus.req_valid_in = '0;
    checks++; if (bus.req_ready_out !== 4'h0) begin errors++; $display("FAIL t2_ready: got %0h expected 0", bus.req_ready_out); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.action_wen_out !== 1'b1) begin errors++; $display("FAIL t2_wen[%0d]: got %0h expected 1", i, bus.action_wen_out); end
      checks++; if (bus.action_thread_id_out !== 2'(i)) begin errors++; $display("FAIL t2_tid[%0d]: got %0h expected %0h", i, bus.action_thread_id_out, i); end
      checks++; if (bus.action_data_out !== 4'(i + 1)) begin errors++; $display("FAIL t2_data[%0d]: got %0h expected %0h", i, bus.action_data_out, i + 1); end
      checks++; if (bus.done_out !== exp_done[i]) begin errors++; $display("FAIL t2_done[%0d]: got %0h expected %0h", i, bus.done_out, exp_done[i]); end
    end
    step();
    checks++; if (bus.done_out !== exp_done[4]) begin errors++; $display("FAIL t2_done_last: got %0h expected %0h", bus.done_out, exp_done[4]); end
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t2_wen_off: got %0h expected 0", bus.action_wen_out); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.req_valid_in = 4'b0100;
    bus.req_data_in  = 16'h0700;
    step();
    bus.req_valid_in = '0;
    step();
    checks++; if (bus.action_wen_out !== 1'b1) begin errors++; $display("FAIL t3_wen_load: got %0h expected 1", bus.action_wen_out); end
    bus.pipe_wena_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (bus.action_wen_out !== 1'b1) begin errors++; $display("FAIL t3_wen[%0d]: got %0h expected 1", k, bus.action_wen_out); end
      checks++; if (bus.action_thread_id_out !== 2'd2) begin errors++; $display("FAIL t3_tid[%0d]: got %0h expected 2", k, bus.action_thread_id_out); end
      checks++; if (bus.action_data_out !== 4'h7) begin errors++; $display("FAIL t3_data[%0d]: got %0h expected 7", k, bus.action_data_out); end
      checks++; if (bus.done_out !== 4'h0) begin errors++; $display("FAIL t3_done[%0d]: got %0h expected 0", k, bus.done_out); end
      checks++; if (bus.stall_count_out !== 8'(k)) begin errors++; $display("FAIL t3_stall[%0d]: got %0d expected %0d", k, bus.stall_count_out, k); end
    end
    bus.pipe_wena_in = 1'b0;
    step();
    checks++; if (bus.done_out !== 4'b0100) begin errors++; $display("FAIL t3_done_commit: got %0h expected 4", bus.done_out); end
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t3_wen_off: got %0h expected 0", bus.action_wen_out); end
    checks++; if (bus.stall_count_out !== 8'd5) begin errors++; $display("FAIL t3_stall_final: got %0d expected 5", bus.stall_count_out); end
  endtask

  task automatic test_fairness();
    int order[$];
    int exp_alt [6];
    int exp_rr  [3];
    exp_alt = '{0, 1, 0, 1, 0, 1};
    exp_rr  = '{1, 2, 0};

    // Threads 0 and 1 re-request as soon as their done pulse arrives.
    do_reset();
    bus.req_valid_in = 4'b0011;
    bus.req_data_in  = 16'h0021;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      logic [3:0] acc;
      acc = bus.req_valid_in & bus.req_ready_out;
      step();
      bus.req_valid_in = bus.req_valid_in & ~acc;
      for (int t = 0; t < 2; t++) begin
        if (bus.done_out[t]) begin
          order.push_back(t);
          bus.req_valid_in[t] = 1'b1;
        end
      end
    end
    bus.req_valid_in = '0;
    checks++; if (order.size() !== 6) begin errors++; $display("FAIL t4_alt_count: got %0d expected 6", order.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) begin
        checks++; if (order[i] !== exp_alt[i]) begin errors++; $display("FAIL t4_alt[%0d]: got %0d expected %0d", i, order[i], exp_alt[i]); end
      end
    end

    // Grant to 1, then 0 and 2 wait together: pointer is past 1, so 2 goes before 0.
    order.delete();
    do_reset();
    bus.req_valid_in = 4'b0010;
    bus.req_data_in  = 16'h0010;
    step();
    bus.req_valid_in = '0;
    step();
    bus.pipe_wena_in = 1'b1;
    bus.req_valid_in = 4'b0101;
    bus.req_data_in  = 16'h0304;
    step();
    bus.req_valid_in = '0;
    step();
    bus.pipe_wena_in = 1'b0;
    for (int cyc = 0; cyc < 20 && order.size() < 3; cyc++) begin
      step();
      for (int t = 0; t < 4; t++) begin
        if (bus.done_out[t]) order.push_back(t);
      end
    end
    checks++; if (order.size() !== 3) begin errors++; $display("FAIL t4_rr_count: got %0d expected 3", order.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < order.size()) begin
        checks++; if (order[i] !== exp_rr[i]) begin errors++; $display("FAIL t4_rr[%0d]: got %0d expected %0d", i, order[i], exp_rr[i]); end
      end
    end
  endtask

  task automatic test_hold_request();
    do_reset();
    bus.req_valid_in = 4'b0010;
    bus.req_data_in  = 16'h0050;
    step();
    bus.req_data_in  = 16'h0090;
    checks++; if (bus.req_ready_out[1] !== 1'b0) begin errors++; $display("FAIL t5_ready_busy: got %0h expected 0", bus.req_ready_out[1]); end
    step();
    checks++; if (bus.action_data_out !== 4'h5) begin errors++; $display("FAIL t5_data_first: got %0h expected 5", bus.action_data_out); end
    checks++; if (bus.action_thread_id_out !== 2'd1) begin errors++; $display("FAIL t5_tid_first: got %0h expected 1", bus.action_thread_id_out); end
    checks++; if (bus.req_ready_out[1] !== 1'b0) begin errors++; $display("FAIL t5_ready_issue: got %0h expected 0", bus.req_ready_out[1]); end
    step();
    checks++; if (bus.done_out !== 4'b0010) begin errors++; $display("FAIL t5_done_first: got %0h expected 2", bus.done_out); end
    checks++; if (bus.req_ready_out[1] !== 1'b1) begin errors++; $display("FAIL t5_ready_free: got %0h expected 1", bus.req_ready_out[1]); end
    step();
    bus.req_valid_in = '0;
    checks++; if (bus.req_ready_out[1] !== 1'b0) begin errors++; $display("FAIL t5_ready_reacc: got %0h expected 0", bus.req_ready_out[1]); end
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t5_wen_gap: got %0h expected 0", bus.action_wen_out); end
    step();
    checks++; if (bus.action_data_out !== 4'h9) begin errors++; $display("FAIL t5_data_second: got %0h expected 9", bus.action_data_out); end
    step();
    checks++; if (bus.done_out !== 4'b0010) begin errors++; $display("FAIL t5_done_second: got %0h expected 2", bus.done_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid_in = 4'b1000;
    bus.req_data_in  = 16'hB000;
    step();
    bus.req_valid_in = '0;
    step();
    checks++; if (bus.action_thread_id_out !== 2'd3) begin errors++; $display("FAIL t6_tid: got %0h expected 3", bus.action_thread_id_out); end
    bus.pipe_wena_in = 1'b1;
    step();
    step();
    checks++; if (bus.stall_count_out !== 8'd2) begin errors++; $display("FAIL t6_stall_pre: got %0d expected 2", bus.stall_count_out); end
    reset = 1'b1;
    step();
    checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t6_wen: got %0h expected 0", bus.action_wen_out); end
    checks++; if (bus.req_ready_out !== 4'hF) begin errors++; $display("FAIL t6_ready: got %0h expected f", bus.req_ready_out); end
    checks++; if (bus.stall_count_out !== 8'd0) begin errors++; $display("FAIL t6_stall: got %0d expected 0", bus.stall_count_out); end
    checks++; if (bus.action_data_out !== 4'h0) begin errors++; $display("FAIL t6_data: got %0h expected 0", bus.action_data_out); end
    reset = 1'b0;
    bus.pipe_wena_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.done_out !== 4'h0) begin errors++; $display("FAIL t6_done[%0d]: got %0h expected 0", k, bus.done_out); end
      checks++; if (bus.action_wen_out !== 1'b0) begin errors++; $display("FAIL t6_wen_after[%0d]: got %0h expected 0", k, bus.action_wen_out); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid_in = '0;
    bus.req_data_in  = '0;
    bus.pipe_wena_in = 1'b0;
    test_reset();
    test_single();
    test_all_threads();
    test_stall();
    test_fairness();
    test_hold_request();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
